// File: rtl/dflash_emu_read_if.sv
// Bus bundle between the CPU-side data-flash decode, the emulation SRAM and
// the memory-data OR bus for the data-flash emulation read sequencer.
interface dflash_emu_read_if #(
  parameter int AW = 12
);
  logic          DFEN;
  logic          DFSEL;
  logic          RDREQ;
  logic [AW-1:0] DFADR;
  logic          EMRD;
  logic [AW-1:0] EMADR;
  logic [15:0]   EMDATA;
  logic [15:0]   DFMDR;
  logic          SLDFLASH;
  logic          DFWAIT;
  logic          DFOVR;
  logic          OVRCLR;

  modport master (
    output DFEN, DFSEL, RDREQ, DFADR, EMDATA, OVRCLR,
    input  EMRD, EMADR, DFMDR, SLDFLASH, DFWAIT, DFOVR
  );

  modport slave (
    input  DFEN, DFSEL, RDREQ, DFADR, EMDATA, OVRCLR,
    output EMRD, EMADR, DFMDR, SLDFLASH, DFWAIT, DFOVR
  );
endinterface

// File: rtl/dflash_emu_read.sv
// Data-flash emulation read sequencer: fetches a word from the emulation SRAM
// with a fixed wait-state count and returns it for one cycle on the OR bus.
module dflash_emu_read #(
  parameter int AW   = 12,
  parameter int WAIT = 2
) (
  input  logic               CLK,
  input  logic               RESB,
  dflash_emu_read_if.slave   bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DRIVE  = 2'd2;
  localparam logic [2:0] WAIT_CNT  = 3'(WAIT);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [2:0]  cnt;
  logic [15:0] data_q;
  logic        req;
  logic        accept;

  assign req    = bus.RDREQ & bus.DFSEL & bus.DFEN;
  assign accept = req & ((state == ST_IDLE) | (state == ST_DRIVE));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
      ST_ACCESS: if (cnt == 3'd0) state_nxt = ST_DRIVE;
      ST_DRIVE:  state_nxt = accept ? ST_ACCESS : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state        <= ST_IDLE;
      cnt          <= 3'd0;
      data_q       <= 16'h0000;
      bus.EMADR    <= '0;
      bus.EMRD     <= 1'b0;
      bus.SLDFLASH <= 1'b0;
      bus.DFWAIT   <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.EMRD     <= accept;
      bus.SLDFLASH <= (state_nxt != ST_IDLE);
      bus.DFWAIT   <= (state_nxt == ST_ACCESS);
      if (accept) begin
        bus.EMADR <= bus.DFADR;
        cnt       <= WAIT_CNT;
      end else if ((state == ST_ACCESS) && (cnt != 3'd0)) begin
        cnt <= cnt - 3'd1;
      end
      if ((state == ST_ACCESS) && (cnt == 3'd0)) begin
        data_q <= bus.EMDATA;
      end
    end
  end

  // A request arriving mid-fetch is dropped; only the sticky flag records it.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      bus.DFOVR <= 1'b0;
    end else if (req && (state == ST_ACCESS)) begin
      bus.DFOVR <= 1'b1;
    end else if (bus.OVRCLR) begin
      bus.DFOVR <= 1'b0;
    end
  end

  assign bus.DFMDR = (state == ST_DRIVE) ? data_q : 16'h0000;

endmodule

// File: tb/tb_dflash_emu_read.sv
// Directed-vector bench for dflash_emu_read with WAIT=2: cycle tables for the
// read paths plus hand-written reset sequences.
module tb_dflash_emu_read;

  typedef struct {
    logic        rdreq;
    logic        dfsel;
    logic        dfen;
    logic        ovrclr;
    logic [11:0] dfadr;
    logic [15:0] emdata;
    logic        emrd;
    logic [11:0] emadr;
    logic [15:0] dfmdr;
    logic        sld;
    logic        dfwait;
    logic        dfovr;
  } vec_t;

  logic CLK = 1'b0;
  logic RESB;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  always #5 CLK = ~CLK;

  dflash_emu_read_if #(.AW(12)) bus ();

  dflash_emu_read #(.AW(12), .WAIT(2)) dut (
    .CLK  (CLK),
    .RESB (RESB),
    .bus  (bus)
  );

  task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkField({tag, " EMRD"},     16'(bus.EMRD),     16'(v.emrd));
    checkField({tag, " EMADR"},    16'(bus.EMADR),    16'(v.emadr));
    checkField({tag, " DFMDR"},    bus.DFMDR,         v.dfmdr);
    checkField({tag, " SLDFLASH"}, 16'(bus.SLDFLASH), 16'(v.sld));
    checkField({tag, " DFWAIT"},   16'(bus.DFWAIT),   16'(v.dfwait));
    checkField({tag, " DFOVR"},    16'(bus.DFOVR),    16'(v.dfovr));
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.RDREQ  = v.rdreq;
    bus.DFSEL  = v.dfsel;
    bus.DFEN   = v.dfen;
    bus.OVRCLR = v.ovrclr;
    bus.DFADR  = v.dfadr;
    bus.EMDATA = v.emdata;
  endtask

  task automatic addVec(input logic rq, input logic sel, input logic en, input logic clr,
                        input logic [11:0] adr, input logic [15:0] emd,
                        input logic emrd, input logic [11:0] emadr, input logic [15:0] mdr,
                        input logic sld, input logic wt, input logic ovr);
    vec_t v;
    v.rdreq = rq;  v.dfsel = sel; v.dfen = en; v.ovrclr = clr;
    v.dfadr = adr; v.emdata = emd;
    v.emrd = emrd; v.emadr = emadr; v.dfmdr = mdr;
    v.sld = sld;   v.dfwait = wt;  v.dfovr = ovr;
    vecs.push_back(v);
  endtask

  // Each vector describes one cycle: inputs driven in it and outputs seen in it.
  task automatic runVecs(input string seg);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("%s[c%0d]", seg, i), vecs[i]);
      @(posedge CLK);
      #1;
    end
    vecs.delete();
  endtask

  task automatic checkAllZero(input string tag);
    vec_t z;
    z.rdreq = 0; z.dfsel = 0; z.dfen = 0; z.ovrclr = 0; z.dfadr = 0; z.emdata = 0;
    z.emrd = 0;  z.emadr = 12'h000; z.dfmdr = 16'h0000; z.sld = 0; z.dfwait = 0; z.dfovr = 0;
    checkOutput(tag, z);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vec_t idle;
    idle.rdreq = 0; idle.dfsel = 0; idle.dfen = 1; idle.ovrclr = 0;
    idle.dfadr = 12'h000; idle.emdata = 16'hDEAD;
    idle.emrd = 0; idle.emadr = 0; idle.dfmdr = 0; idle.sld = 0; idle.dfwait = 0; idle.dfovr = 0;
    applyStimulus(idle);
    RESB = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkAllZero("reset held");
    RESB = 1'b1;
    tick();
    checkAllZero("reset released");
    bus.OVRCLR = 1'b1;
    tick();
    bus.OVRCLR = 1'b0;
    checkField("ovrclr after reset DFOVR", 16'(bus.DFOVR), 16'h0);

    // Single read then back-to-back read accepted in the DRIVE cycle
    //      rq sel en clr adr      emdata     emrd emadr    dfmdr     sld wt ovr
    addVec(1, 1, 1, 0, 12'h123, 16'hDEAD,  0, 12'h000, 16'h0000, 0, 0, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'hDEAD,  1, 12'h123, 16'h0000, 1, 1, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'hDEAD,  0, 12'h123, 16'h0000, 1, 1, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'hA55A,  0, 12'h123, 16'h0000, 1, 1, 0);
    addVec(1, 1, 1, 0, 12'h124, 16'hDEAD,  0, 12'h123, 16'hA55A, 1, 0, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'hDEAD,  1, 12'h124, 16'h0000, 1, 1, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'hDEAD,  0, 12'h124, 16'h0000, 1, 1, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'h0F0F,  0, 12'h124, 16'h0000, 1, 1, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'hDEAD,  0, 12'h124, 16'h0F0F, 1, 0, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'hDEAD,  0, 12'h124, 16'h0000, 0, 0, 0);
    runVecs("b2b");

    // Overrun while busy, clear racing a new overrun, then clear alone
    addVec(1, 1, 1, 0, 12'h200, 16'hDEAD,  0, 12'h124, 16'h0000, 0, 0, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'hDEAD,  1, 12'h200, 16'h0000, 1, 1, 0);
    addVec(1, 1, 1, 0, 12'h3FF, 16'hDEAD,  0, 12'h200, 16'h0000, 1, 1, 0);
    addVec(1, 1, 1, 1, 12'h3FF, 16'hBEEF,  0, 12'h200, 16'h0000, 1, 1, 1);
    addVec(0, 0, 1, 1, 12'h000, 16'hDEAD,  0, 12'h200, 16'hBEEF, 1, 0, 1);
    addVec(0, 0, 1, 0, 12'h000, 16'hDEAD,  0, 12'h200, 16'h0000, 0, 0, 0);
    runVecs("ovr");

    // Gating by DFSEL/DFEN, and DFEN dropping mid-fetch
    addVec(1, 0, 1, 0, 12'h0AA, 16'hDEAD,  0, 12'h200, 16'h0000, 0, 0, 0);
    addVec(1, 1, 0, 0, 12'h0BB, 16'hDEAD,  0, 12'h200, 16'h0000, 0, 0, 0);
    addVec(1, 1, 1, 0, 12'h055, 16'hDEAD,  0, 12'h200, 16'h0000, 0, 0, 0);
    addVec(1, 0, 1, 0, 12'h0DD, 16'hDEAD,  1, 12'h055, 16'h0000, 1, 1, 0);
    addVec(0, 0, 0, 0, 12'h000, 16'hDEAD,  0, 12'h055, 16'h0000, 1, 1, 0);
    addVec(1, 1, 0, 0, 12'h0EE, 16'h7777,  0, 12'h055, 16'h0000, 1, 1, 0);
    addVec(1, 1, 0, 0, 12'h0CC, 16'hDEAD,  0, 12'h055, 16'h7777, 1, 0, 0);
    addVec(0, 0, 0, 0, 12'h000, 16'hDEAD,  0, 12'h055, 16'h0000, 0, 0, 0);
    runVecs("gate");

    // Reset mid-fetch, with an overrun already flagged
    bus.DFEN = 1'b1; bus.DFSEL = 1'b1; bus.RDREQ = 1'b1; bus.DFADR = 12'h321;
    tick();
    bus.DFADR = 12'h3AB;
    tick();
    bus.RDREQ = 1'b0; bus.DFSEL = 1'b0; bus.EMDATA = 16'hCAFE;
    checkField("pre-reset DFOVR", 16'(bus.DFOVR), 16'h1);
    checkField("pre-reset EMADR", 16'(bus.EMADR), 16'h321);
    #2;
    RESB = 1'b0;
    #1;
    checkAllZero("async reset mid-fetch");
    tick();
    RESB = 1'b1;
    tick();
    checkAllZero("after mid-fetch reset");
    tick();
    checkAllZero("no stale drive");

    addVec(1, 1, 1, 0, 12'h010, 16'hDEAD,  0, 12'h000, 16'h0000, 0, 0, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'hDEAD,  1, 12'h010, 16'h0000, 1, 1, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'hDEAD,  0, 12'h010, 16'h0000, 1, 1, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'h1234,  0, 12'h010, 16'h0000, 1, 1, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'hDEAD,  0, 12'h010, 16'h1234, 1, 0, 0);
    addVec(0, 0, 1, 0, 12'h000, 16'hDEAD,  0, 12'h010, 16'h0000, 0, 0, 0);
    runVecs("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
